// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: default operand width and FSM encoding.
package shift_add_multiplier_pkg;

  localparam int unsigned DEFAULT_WORD_LENGTH = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StRun  = RUN,
    StDone = DONE
  } state_e;

endpackage

// File: rtl/iteration_counter.sv
// Up-counter with synchronous clear and enable; flags the terminal iteration value.
module iteration_counter #(
  parameter int unsigned      WIDTH = 3,
  parameter logic [WIDTH-1:0] LAST  = '1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign terminal = (count_q == LAST);

endmodule

// File: rtl/shift_add_multiplier.sv
// Unsigned sequential shift-and-add multiplier, one multiplier bit per clock; done pulses
// for one cycle alongside a freshly registered product.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = DEFAULT_WORD_LENGTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WORD_LENGTH-1:0]     multiplicand,
  input  logic [WORD_LENGTH-1:0]     multiplier,
  output logic [2*WORD_LENGTH-1:0]   product,
  output logic                       done,
  output logic                       ready
);

  localparam int unsigned CntWidth = $clog2(WORD_LENGTH) + 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(WORD_LENGTH - 1);

  state_e                     state_q, state_d;
  logic [2*WORD_LENGTH-1:0]   a_sh_q, a_sh_d;
  logic [WORD_LENGTH-1:0]     b_sh_q, b_sh_d;
  logic [2*WORD_LENGTH-1:0]   acc_q, acc_d;
  logic [2*WORD_LENGTH-1:0]   product_q, product_d;
  logic                       cnt_clear, cnt_en, cnt_last;

  iteration_counter #(
    .WIDTH (CntWidth),
    .LAST  (CntLast)
  ) u_iteration_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .terminal (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    acc_d     = acc_q;
    product_d = product_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d    = {{WORD_LENGTH{1'b0}}, multiplicand};
          b_sh_d    = multiplier;
          acc_d     = '0;
          cnt_clear = 1'b1;
          state_d   = StRun;
        end
      end
      StRun: begin
        cnt_en = 1'b1;
        acc_d  = b_sh_q[0] ? (acc_q + a_sh_q) : acc_q;
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q >> 1;
        // Last iteration: publish the accumulator including this cycle's partial product.
        if (cnt_last) begin
          product_d = acc_d;
          state_d   = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;
  assign done    = (state_q == StDone);
  assign ready   = (state_q == StIdle);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier (W=4) against a plain-arithmetic product model.
module tb_shift_add_multiplier;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic [2*W-1:0] product;
  logic           done;
  logic           ready;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(
    .WORD_LENGTH (W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .done         (done),
    .ready        (ready)
  );

  // Downstream enable-gated register, as used in the system.
  logic [2*W-1:0] out_reg;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out_reg <= '0;
    else if (done) out_reg <= product;
  end

  // done must never stay high two cycles running.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_cmp++;
      if (prev_done === 1'b1) begin
        n_fail++;
        $display("FAIL done_consecutive: got done=1 twice in a row, required single-cycle pulse");
      end
    end
    prev_done = done;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int k;
    logic [2*W-1:0] exp;
    exp = (2*W)'(a) * (2*W)'(b);
    k = 0;
    while (ready !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    n_cmp++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_wait: got ready=%b, required 1", tag, ready);
    end
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    step();
    start        = 1'b0;
    multiplicand = W'($urandom);
    multiplier   = W'($urandom);
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    n_cmp++;
    if (k != W) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges, required %0d", tag, k, W);
    end
    n_cmp++;
    if (product !== exp) begin
      n_fail++;
      $display("FAIL %s product (%0d*%0d): got %0d, required %0d", tag, a, b, product, exp);
    end
    step();
    n_cmp++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_done: got ready=%b done=%b, required ready=1 done=0",
               tag, ready, done);
    end
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    #12;
    n_cmp++;
    if (product !== '0 || done !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got product=%0d done=%b ready=%b, required 0/0/1",
               product, done, ready);
    end
    #1 reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    run_op(4'd13, 4'd11, "basic_13x11");
  endtask

  task automatic test_corners();
    run_op(4'd15, 4'd15, "max_15x15");
    run_op(4'd0, 4'd9, "zero_0x9");
    run_op(4'd7, 4'd0, "zero_7x0");
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      run_op(W'($urandom), W'($urandom), "random");
    end
  endtask

  task automatic test_busy_start();
    int pulses;
    logic [2*W-1:0] seen;
    pulses = 0;
    seen   = '0;
    multiplicand = 4'd6;
    multiplier   = 4'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    multiplicand = 4'd2;
    multiplier   = 4'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) begin
        pulses++;
        seen = product;
      end
      step();
    end
    n_cmp++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL busy_start pulses: got %0d, required 1", pulses);
    end
    n_cmp++;
    if (seen !== 8'd42) begin
      n_fail++;
      $display("FAIL busy_start product: got %0d, required 42", seen);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    multiplicand = 4'd13;
    multiplier   = 4'd11;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (product !== '0 || done !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: got product=%0d done=%b ready=%b, required 0/0/1",
               product, done, ready);
    end
    #1 reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0 || product !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_after: got pulses=%0d product=%0d, required 0/0",
               pulses, product);
    end
  endtask

  task automatic test_held_start();
    int pulses;
    int cyc_at[3];
    pulses = 0;
    multiplicand = 4'd3;
    multiplier   = 4'd5;
    start = 1'b1;
    for (int cyc = 1; cyc <= 40 && pulses < 3; cyc++) begin
      step();
      if (done === 1'b1) begin
        cyc_at[pulses] = cyc;
        pulses++;
        n_cmp++;
        if (product !== 8'd15) begin
          n_fail++;
          $display("FAIL held_start product: got %0d, required 15", product);
        end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (pulses != 3) begin
      n_fail++;
      $display("FAIL held_start pulses: got %0d, required 3", pulses);
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_cmp++;
        if (cyc_at[i] - cyc_at[i-1] != W + 2) begin
          n_fail++;
          $display("FAIL held_start spacing: got %0d, required %0d",
                   cyc_at[i] - cyc_at[i-1], W + 2);
        end
      end
    end
    step();
    step();
  endtask

  task automatic test_output_register();
    int k;
    run_op(4'd13, 4'd11, "outreg_first");
    n_cmp++;
    if (out_reg !== 8'd143) begin
      n_fail++;
      $display("FAIL outreg_capture: got %0d, required 143", out_reg);
    end
    multiplicand = 4'd3;
    multiplier   = 4'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      n_cmp++;
      if (out_reg !== 8'd143) begin
        n_fail++;
        $display("FAIL outreg_hold: got %0d, required 143", out_reg);
      end
      step();
      k++;
    end
    n_cmp++;
    if (done !== 1'b1 || out_reg !== 8'd143) begin
      n_fail++;
      $display("FAIL outreg_at_done: got done=%b out_reg=%0d, required 1/143", done, out_reg);
    end
    step();
    n_cmp++;
    if (out_reg !== 8'd15) begin
      n_fail++;
      $display("FAIL outreg_second: got %0d, required 15", out_reg);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_busy_start();
    test_reset_mid();
    test_held_start();
    test_output_register();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
